alu_seq_unit: RTL and testbench

- Parametrised ALU control and execute unit. Decodes aluop/funct into an operation and executes it in one place.
- Single-cycle ops complete with registered latency 1. MUL, DIVU and REMU run as iterative multi-cycle operations.
- Sits in the execute stage. The input side is a valid/ready handshake from decode; the output side is a valid/ready handshake to writeback.

---
 rtl/alu_seq_if.sv | 32 +++
 rtl/alu_seq_unit.sv | 185 ++++++++++++++++++
 tb/tb_alu_seq_unit.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Purpose: request/response bundle between decode, the ALU unit and writeback.
// Latency: none (wires only).
// Backpressure: in_valid/in_ready on the request side, out_valid/out_ready on the result side.
//
// master: decode/writeback side (drives requests and out_ready).
// slave : alu_seq_unit (drives in_ready, result, zero, illegal, busy).
interface alu_seq_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      aluop;
    logic [5:0]      funct;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal;
    logic            busy;

    modport master (
        output in_valid, aluop, funct, src_a, src_b, out_ready,
        input  in_ready, out_valid, result, zero, illegal, busy
    );

    modport slave (
        input  in_valid, aluop, funct, src_a, src_b, out_ready,
        output in_ready, out_valid, result, zero, illegal, busy
    );
endinterface

// File: rtl/alu_seq_unit.sv
// Purpose: execute-stage ALU; decodes aluop/funct and runs single-cycle ops or iterative MUL/DIVU/REMU.
// Latency: 1 cycle for single-cycle, illegal and divide-by-zero ops; XLEN+1 cycles for MUL/DIVU/REMU.
// Backpressure: result held in DONE until out_ready; new request accepted in IDLE or in DONE when out_ready.
//
// Ports: clk, rst_n (async active-low); io (alu_seq_if.slave): in_valid/in_ready, aluop, funct,
//        src_a, src_b, out_valid/out_ready, result, zero, illegal, busy.
module alu_seq_unit #(
    parameter int XLEN  = 32,
    parameter bit MD_EN = 1'b1
) (
    input  logic      clk,
    input  logic      rst_n,
    alu_seq_if.slave  io
);
    localparam int SHW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU,
        OP_SLL, OP_SRL, OP_SRA, OP_MUL, OP_DIVU, OP_REMU, OP_ILL
    } op_t;

    state_t          state;
    op_t             dec_op;
    op_t             mc_op;      // multi-cycle op in flight
    logic [SHW-1:0]  cnt;
    logic [XLEN:0]   acc;        // MUL: partial product; DIV: partial remainder
    logic [XLEN-1:0] opa;        // MUL: shifted multiplicand; DIV: dividend shifting into quotient
    logic [XLEN-1:0] opb;        // MUL: multiplier shifting right; DIV: divisor
    logic [XLEN-1:0] res_q;
    logic            ill_q;
    logic            vld_q;
    logic            busy_q;

    logic            in_ready_c;
    logic            accept;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] sc_res;
    logic            goes_calc;
    logic [XLEN:0]   mul_acc;
    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   rem_n;
    logic            ge;
    logic [XLEN-1:0] quo_n;

    assign in_ready_c   = (state == IDLE) || ((state == DONE) && io.out_ready);
    assign accept       = io.in_valid && in_ready_c;
    assign shamt        = io.src_b[SHW-1:0];

    assign io.in_ready  = in_ready_c;
    assign io.out_valid = vld_q;
    assign io.result    = res_q;
    assign io.illegal   = ill_q;
    assign io.busy      = busy_q;
    assign io.zero      = (res_q == '0);

    always_comb begin
        dec_op = OP_ILL;
        case (io.aluop)
            2'b00: dec_op = OP_ADD;
            2'b01: dec_op = OP_SUB;
            2'b10: begin
                case (io.funct)
                    6'b100000: dec_op = OP_ADD;
                    6'b100010: dec_op = OP_SUB;
                    6'b100100: dec_op = OP_AND;
                    6'b100101: dec_op = OP_OR;
                    6'b100110: dec_op = OP_XOR;
                    6'b100111: dec_op = OP_NOR;
                    6'b101010: dec_op = OP_SLT;
                    6'b101011: dec_op = OP_SLTU;
                    6'b000000: dec_op = OP_SLL;
                    6'b000010: dec_op = OP_SRL;
                    6'b000011: dec_op = OP_SRA;
                    6'b011000: dec_op = MD_EN ? OP_MUL  : OP_ILL;
                    6'b011011: dec_op = MD_EN ? OP_DIVU : OP_ILL;
                    6'b011111: dec_op = MD_EN ? OP_REMU : OP_ILL;
                    default:   dec_op = OP_ILL;
                endcase
            end
            default: dec_op = OP_ILL;
        endcase
    end

    // Single-cycle result; DIVU/REMU entries are the divide-by-zero answers,
    // only used when the divisor is zero and CALC is skipped.
    always_comb begin
        sc_res = '0;
        case (dec_op)
            OP_ADD:  sc_res = io.src_a + io.src_b;
            OP_SUB:  sc_res = io.src_a - io.src_b;
            OP_AND:  sc_res = io.src_a & io.src_b;
            OP_OR:   sc_res = io.src_a | io.src_b;
            OP_XOR:  sc_res = io.src_a ^ io.src_b;
            OP_NOR:  sc_res = ~(io.src_a | io.src_b);
            OP_SLT:  sc_res = {{(XLEN-1){1'b0}}, ($signed(io.src_a) < $signed(io.src_b))};
            OP_SLTU: sc_res = {{(XLEN-1){1'b0}}, (io.src_a < io.src_b)};
            OP_SLL:  sc_res = io.src_a << shamt;
            OP_SRL:  sc_res = io.src_a >> shamt;
            OP_SRA:  sc_res = $signed(io.src_a) >>> shamt;
            OP_DIVU: sc_res = '1;
            OP_REMU: sc_res = io.src_a;
            default: sc_res = '0;
        endcase
    end

    assign goes_calc = (dec_op == OP_MUL) ||
                       (((dec_op == OP_DIVU) || (dec_op == OP_REMU)) && (io.src_b != '0));

    // One shift-add step and one restoring-division step per CALC cycle.
    assign mul_acc = acc + (opb[0] ? {1'b0, opa} : '0);
    assign rem_sh  = {acc[XLEN-1:0], opa[XLEN-1]};
    assign ge      = (rem_sh >= {1'b0, opb});
    assign rem_n   = ge ? (rem_sh - {1'b0, opb}) : rem_sh;
    assign quo_n   = {opa[XLEN-2:0], ge};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            mc_op  <= OP_ADD;
            cnt    <= '0;
            acc    <= '0;
            opa    <= '0;
            opb    <= '0;
            res_q  <= '0;
            ill_q  <= 1'b0;
            vld_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        if (goes_calc) begin
                            state  <= CALC;
                            busy_q <= 1'b1;
                            vld_q  <= 1'b0;
                            cnt    <= '0;
                            acc    <= '0;
                            opa    <= io.src_a;
                            opb    <= io.src_b;
                            mc_op  <= dec_op;
                        end else begin
                            state  <= DONE;
                            vld_q  <= 1'b1;
                            res_q  <= sc_res;
                            ill_q  <= (dec_op == OP_ILL);
                        end
                    end else if ((state == DONE) && io.out_ready) begin
                        state <= IDLE;
                        vld_q <= 1'b0;
                    end
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    if (mc_op == OP_MUL) begin
                        acc <= mul_acc;
                        opa <= opa << 1;
                        opb <= opb >> 1;
                    end else begin
                        acc <= rem_n;
                        opa <= quo_n;
                    end
                    if (cnt == SHW'(XLEN - 1)) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        vld_q  <= 1'b1;
                        ill_q  <= 1'b0;
                        cnt    <= '0;
                        if (mc_op == OP_MUL)
                            res_q <= mul_acc[XLEN-1:0];
                        else if (mc_op == OP_DIVU)
                            res_q <= quo_n;
                        else
                            res_q <= rem_n[XLEN-1:0];
                    end
                end
                default: begin
                    state  <= IDLE;
                    vld_q  <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq_unit.sv
// Purpose: self-checking bench for alu_seq_unit (directed literals plus randomized traffic vs a reference model).
// Latency: expects 1 cycle for single-cycle ops, XLEN+1 for MUL/DIVU/REMU.
// Backpressure: drives out_ready held, toggled and random; tracks one outstanding request.
module tb_alu_seq_unit;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_seq_if #(.XLEN(XLEN)) bus();

    alu_seq_unit #(.XLEN(XLEN), .MD_EN(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit rand_rdy  = 1'b0;
    bit force_rdy = 1'b1;

    typedef struct {
        logic [31:0] r;
        bit          ill;
        int          rdy;
        int          lat;
    } txn_t;
    txn_t q[$];

    always @(posedge clk) cyc++;

    // Sole driver of out_ready; updates a little after each rising edge.
    always @(posedge clk) begin
        #2;
        bus.out_ready = rand_rdy ? ($urandom % 4 != 0) : force_rdy;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: what the op must produce, straight from the arithmetic meaning.
    task automatic model(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] a,
                         input logic [31:0] b, output logic [31:0] r, output bit ill, output int lat);
        r = '0; ill = 1'b0; lat = 1;
        case (op)
            2'b00: r = a + b;
            2'b01: r = a - b;
            2'b10: begin
                case (fn)
                    6'h20: r = a + b;
                    6'h22: r = a - b;
                    6'h24: r = a & b;
                    6'h25: r = a | b;
                    6'h26: r = a ^ b;
                    6'h27: r = ~(a | b);
                    6'h2a: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    6'h2b: r = (a < b) ? 32'd1 : 32'd0;
                    6'h00: r = a << b[4:0];
                    6'h02: r = a >> b[4:0];
                    6'h03: r = $unsigned($signed(a) >>> b[4:0]);
                    6'h18: begin r = a * b; lat = XLEN + 1; end
                    6'h1b: if (b == 0) r = '1; else begin r = a / b; lat = XLEN + 1; end
                    6'h1f: if (b == 0) r = a;  else begin r = a % b; lat = XLEN + 1; end
                    default: ill = 1'b1;
                endcase
            end
            default: ill = 1'b1;
        endcase
    endtask

    // Per-cycle compare of every output against the model's outstanding request.
    always @(negedge clk) begin : cmp
        bit ev, eb, er;
        logic [31:0] mr;
        bit mi;
        int ml;
        if (!rst_n) begin
            chk("rst_out_valid", bus.out_valid, 0);
            chk("rst_busy", bus.busy, 0);
            chk("rst_in_ready", bus.in_ready, 1);
            q.delete();
        end else begin
            ev = (q.size() > 0) && (cyc >= q[0].rdy);
            eb = (q.size() > 0) && (q[0].lat > 1) && (cyc < q[0].rdy);
            er = (q.size() == 0) || (ev && bus.out_ready);
            chk("out_valid", bus.out_valid, ev);
            chk("busy", bus.busy, eb);
            chk("in_ready", bus.in_ready, er);
            if (ev && bus.out_valid) begin
                chk("result", bus.result, q[0].r);
                chk("illegal", bus.illegal, q[0].ill);
                chk("zero", bus.zero, (q[0].r == 0));
                if (bus.out_ready) void'(q.pop_front());
            end
            if (bus.in_valid && bus.in_ready) begin
                model(bus.aluop, bus.funct, bus.src_a, bus.src_b, mr, mi, ml);
                q.push_back('{r: mr, ill: mi, rdy: cyc + ml, lat: ml});
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
    task automatic issue(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] a,
                         input logic [31:0] b, output int acyc);
        bit ok;
        ok = 1'b0;
        acyc = -1;
        bus.in_valid = 1'b1; bus.aluop = op; bus.funct = fn; bus.src_a = a; bus.src_b = b;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin acyc = cyc; ok = 1'b1; break; end
        end
        if (!ok) chk("issue_timeout", 0, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic directed(input string nm, input logic [1:0] op, input logic [5:0] fn,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] er, input bit ei, input int el);
        int acyc, bcnt;
        bit got;
        got = 1'b0; bcnt = 0;
        force_rdy = 1'b1;
        issue(op, fn, a, b, acyc);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.busy) bcnt++;
            if (bus.out_valid) begin got = 1'b1; break; end
        end
        chk({nm, "_valid"}, got, 1);
        if (got) begin
            chk({nm, "_latency"}, cyc - acyc, el);
            chk({nm, "_result"}, bus.result, er);
            chk({nm, "_illegal"}, bus.illegal, ei);
            chk({nm, "_zero"}, bus.zero, (er == 0));
            chk({nm, "_busy_cycles"}, bcnt, el - 1);
        end
        @(posedge clk); #1;
    endtask

    task automatic pin(input string nm, input logic [1:0] op, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input bit ei, input int el);
        logic [31:0] r;
        bit ill;
        int lat;
        model(op, fn, a, b, r, ill, lat);
        chk({"model_", nm, "_r"}, r, er);
        chk({"model_", nm, "_ill"}, ill, ei);
        chk({"model_", nm, "_lat"}, lat, el);
    endtask

    initial begin : drv
        int acyc, nv, n;
        logic [5:0] fl [15];
        logic [1:0] op;
        logic [31:0] a, b;
        bit drained;
        fl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b,
               6'h00, 6'h02, 6'h03, 6'h18, 6'h1b, 6'h1f, 6'h3f};
        bus.in_valid = 1'b0; bus.aluop = 2'b00; bus.funct = 6'h00;
        bus.src_a = '0; bus.src_b = '0;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_result", bus.result, 0);
        chk("reset_illegal", bus.illegal, 0);
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_in_ready", bus.in_ready, 1);
        @(posedge clk); #1;

        pin("add",   2'b10, 6'h20, 32'd5, 32'd7, 32'd12, 0, 1);
        pin("sra",   2'b10, 6'h03, 32'h8000_0000, 32'h24, 32'hF800_0000, 0, 1);
        pin("mul",   2'b10, 6'h18, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, 0, 33);
        pin("divu",  2'b10, 6'h1b, 32'd100, 32'd7, 32'd14, 0, 33);
        pin("remu0", 2'b10, 6'h1f, 32'd9, 32'd0, 32'd9, 0, 1);
        pin("ill",   2'b11, 6'h20, 32'd1, 32'd2, 32'd0, 1, 1);

        directed("add",    2'b10, 6'h20, 32'd5, 32'd7, 32'd12, 0, 1);
        directed("sub",    2'b10, 6'h22, 32'd7, 32'd7, 32'd0, 0, 1);
        directed("slt",    2'b10, 6'h2a, 32'hFFFF_FFFF, 32'd1, 32'd1, 0, 1);
        directed("sltu",   2'b10, 6'h2b, 32'hFFFF_FFFF, 32'd1, 32'd0, 0, 1);
        directed("sra",    2'b10, 6'h03, 32'h8000_0000, 32'h24, 32'hF800_0000, 0, 1);
        directed("srl",    2'b10, 6'h02, 32'h8000_0000, 32'h24, 32'h0800_0000, 0, 1);
        directed("mul",    2'b10, 6'h18, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, 0, 33);
        directed("divu",   2'b10, 6'h1b, 32'd100, 32'd7, 32'd14, 0, 33);
        directed("remu",   2'b10, 6'h1f, 32'd100, 32'd7, 32'd2, 0, 33);
        directed("divu0",  2'b10, 6'h1b, 32'd9, 32'd0, 32'hFFFF_FFFF, 0, 1);
        directed("remu0",  2'b10, 6'h1f, 32'd9, 32'd0, 32'd9, 0, 1);
        directed("aluadd", 2'b00, 6'h3f, 32'd10, 32'd20, 32'd30, 0, 1);
        directed("alusub", 2'b01, 6'h3f, 32'd3, 32'd5, 32'hFFFF_FFFE, 0, 1);
        directed("ill_op", 2'b11, 6'h20, 32'd5, 32'd7, 32'd0, 1, 1);
        directed("ill_fn", 2'b10, 6'h3f, 32'd5, 32'd7, 32'd0, 1, 1);

        // Backpressure then back-to-back issue.
        force_rdy = 1'b0;
        issue(2'b10, 6'h24, 32'h0000_F0F0, 32'h0000_FF00, acyc);
        nv = 0;
        for (int k = 0; k < 10 && nv == 0; k++) begin
            @(negedge clk);
            if (bus.out_valid) nv = 1;
        end
        chk("bp_and_valid", nv, 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_hold_result", bus.result, 32'h0000_F000);
            chk("bp_hold_in_ready", bus.in_ready, 0);
        end
        @(posedge clk); #1;
        force_rdy = 1'b1;
        issue(2'b10, 6'h25, 32'h0000_F0F0, 32'h0000_FF00, acyc);
        @(negedge clk);
        chk("b2b_or_valid", bus.out_valid, 1);
        chk("b2b_or_latency", cyc - acyc, 1);
        chk("b2b_or_result", bus.result, 32'h0000_FFF0);
        @(posedge clk); #1;

        // Reset in the middle of a MUL.
        issue(2'b10, 6'h18, 32'd12345, 32'd678, acyc);
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_busy", bus.busy, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        nv = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.out_valid || bus.busy) nv++;
        end
        chk("midrst_no_result", nv, 0);
        chk("midrst_in_ready", bus.in_ready, 1);
        @(posedge clk); #1;
        directed("post_rst_add", 2'b10, 6'h20, 32'd3, 32'd4, 32'd7, 0, 1);

        // Randomized traffic with random backpressure.
        rand_rdy = 1'b1;
        for (int i = 0; i < 400; i++) begin
            case ($urandom % 8)
                0:       op = 2'b00;
                1:       op = 2'b01;
                2:       op = 2'b11;
                default: op = 2'b10;
            endcase
            a = $urandom;
            b = ($urandom % 4 == 0) ? ($urandom % 4) : $urandom;
            issue(op, fl[$urandom % 15], a, b, acyc);
            n = $urandom % 3;
            for (int j = 0; j < n; j++) begin @(posedge clk); #1; end
        end
        rand_rdy = 1'b0;
        force_rdy = 1'b1;
        drained = 1'b0;
        for (int k = 0; k < 80 && !drained; k++) begin
            @(negedge clk);
            if (q.size() == 0 && !bus.out_valid) drained = 1'b1;
        end
        chk("drain", drained, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
